// File: rtl/mask_region_ctrl.sv
// Rectangular-region pixel mask with shadow config committed atomically at frame start.
// Optional MASK_BORDER_EN: regions hit only on their perimeter (outline debug).
//   state   | meaning
//   IDLE    | host may write shadow config; cfg_ready=1
//   PENDING | commit requested, waiting for frame_start; writes stalled
module mask_region_ctrl #(
  parameter int NREG = 8,
  parameter int XW   = 10,
  parameter int YW   = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic          pix_valid,
  input  logic [XW-1:0] tv_x,
  input  logic [YW-1:0] tv_y,
  input  logic          cfg_wr,
  input  logic [5:0]    cfg_addr,
  input  logic [9:0]    cfg_data,
  output logic          cfg_ready,
  input  logic          cfg_commit,
  output logic          commit_pending,
  output logic          commit_done,
  output logic [10:0]   mask,
  output logic          mask_valid
);

  typedef enum logic [0:0] {IDLE, PENDING} state_t;

  state_t state, state_nxt;

  logic [XW-1:0]   sh_xmin [NREG];
  logic [XW-1:0]   sh_xmax [NREG];
  logic [YW-1:0]   sh_ymin [NREG];
  logic [YW-1:0]   sh_ymax [NREG];
  logic [NREG-1:0] sh_en;

  logic [XW-1:0]   act_xmin [NREG];
  logic [XW-1:0]   act_xmax [NREG];
  logic [YW-1:0]   act_ymin [NREG];
  logic [YW-1:0]   act_ymax [NREG];
  logic [NREG-1:0] act_en;

  logic [XW-1:0]   eff_xmin [NREG];
  logic [XW-1:0]   eff_xmax [NREG];
  logic [YW-1:0]   eff_ymin [NREG];
  logic [YW-1:0]   eff_ymax [NREG];
  logic [NREG-1:0] eff_en;

  logic        wr_acc;
  logic        commit_now;
  logic [2:0]  wr_reg;
  logic [1:0]  wr_fld;
  logic [7:0]  in_rect;
  logic [7:0]  hit;
  logic [1:0]  low_idx;
  logic [10:0] mask_nxt;

  assign cfg_ready      = (state == IDLE);
  assign commit_pending = (state == PENDING);
  assign wr_acc         = cfg_wr && cfg_ready;
  assign commit_now     = (state == PENDING) && frame_start;
  assign wr_reg         = cfg_addr[4:2];
  assign wr_fld         = cfg_addr[1:0];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_commit)  state_nxt = PENDING;
      PENDING: if (frame_start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Writes to region indices >= NREG match no slot and are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_en <= '0;
      for (int r = 0; r < NREG; r++) begin
        sh_xmin[r] <= '0;
        sh_xmax[r] <= '0;
        sh_ymin[r] <= '0;
        sh_ymax[r] <= '0;
      end
    end else if (wr_acc) begin
      if (cfg_addr[5]) begin
        sh_en <= cfg_data[NREG-1:0];
      end else begin
        for (int r = 0; r < NREG; r++) begin
          if (wr_reg == 3'(r)) begin
            case (wr_fld)
              2'd0:    sh_xmin[r] <= XW'(cfg_data);
              2'd1:    sh_xmax[r] <= XW'(cfg_data);
              2'd2:    sh_ymin[r] <= YW'(cfg_data);
              default: sh_ymax[r] <= YW'(cfg_data);
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      act_en      <= '0;
      commit_done <= 1'b0;
      for (int r = 0; r < NREG; r++) begin
        act_xmin[r] <= '0;
        act_xmax[r] <= '0;
        act_ymin[r] <= '0;
        act_ymax[r] <= '0;
      end
    end else begin
      commit_done <= commit_now;
      if (commit_now) begin
        act_en <= sh_en;
        for (int r = 0; r < NREG; r++) begin
          act_xmin[r] <= sh_xmin[r];
          act_xmax[r] <= sh_xmax[r];
          act_ymin[r] <= sh_ymin[r];
          act_ymax[r] <= sh_ymax[r];
        end
      end
    end
  end

  // On the commit edge the pixel is judged against the incoming set, so bypass
  // the shadow straight into the compare; shadow is frozen while PENDING.
  always_comb begin
    eff_en = commit_now ? sh_en : act_en;
    for (int r = 0; r < NREG; r++) begin
      eff_xmin[r] = commit_now ? sh_xmin[r] : act_xmin[r];
      eff_xmax[r] = commit_now ? sh_xmax[r] : act_xmax[r];
      eff_ymin[r] = commit_now ? sh_ymin[r] : act_ymin[r];
      eff_ymax[r] = commit_now ? sh_ymax[r] : act_ymax[r];
    end
  end

  always_comb begin
    in_rect = '0;
    hit     = '0;
    for (int r = 0; r < NREG; r++) begin
      in_rect[r] = eff_en[r]
                   && (tv_x >= eff_xmin[r]) && (tv_x <= eff_xmax[r])
                   && (tv_y >= eff_ymin[r]) && (tv_y <= eff_ymax[r]);
`ifdef MASK_BORDER_EN
      hit[r] = in_rect[r] && ((tv_x == eff_xmin[r]) || (tv_x == eff_xmax[r])
                           || (tv_y == eff_ymin[r]) || (tv_y == eff_ymax[r]));
`else
      hit[r] = in_rect[r];
`endif
    end
  end

  always_comb begin
    low_idx = 2'd0;
    for (int r = 7; r >= 0; r--) begin
      if (hit[r]) low_idx = 2'(r);
    end
    mask_nxt = {low_idx, |hit, hit};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask       <= '0;
      mask_valid <= 1'b0;
    end else begin
      mask_valid <= pix_valid;
      if (pix_valid) mask <= mask_nxt;
    end
  end

endmodule

// File: doc/mask_region_ctrl.md
Name: mask_region_ctrl

Overview:
- Programmable rectangular-region mask generator for the video pipeline.
- Replaces hard-coded per-pixel mask compares with up to NREG host-configured rectangles.
- Holds shadow configuration written over a simple valid/ready interface and commits it atomically at the next frame start, so a frame is never masked with half-updated regions.
- Sits between the tv_x/tv_y raster counters and the fish-detection logic; produces the 11-bit mask per pixel.

Parameters:
- NREG, 8, number of regions (legal 1..8).
- XW, 10, width of tv_x and the X bounds.
- YW, 10, width of tv_y and the Y bounds.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse at first pixel of a frame.
- pix_valid  in  1  tv_x/tv_y valid this cycle.
- tv_x  in  XW  pixel column.
- tv_y  in  YW  pixel row.
- cfg_wr  in  1  config write request.
- cfg_addr  in  6  [5]=0: region field {region[4:2], field[1:0]}; [5]=1: enable register.
- cfg_data  in  10  write data; field 0 x_min, 1 x_max, 2 y_min, 3 y_max; enable reg uses [7:0].
- cfg_ready  out  1  write accepted when cfg_wr && cfg_ready.
- cfg_commit  in  1  request shadow-to-active copy at next frame_start.
- commit_pending  out  1  commit requested, not yet applied.
- commit_done  out  1  one-cycle pulse when active set updated.
- mask  out  11  [7:0] per-region hit, [8] any hit, [10:9] lowest hit region index bits [1:0]... see Behaviour.
- mask_valid  out  1  mask qualifies pixel from previous cycle.

Behaviour:
- Reset (sync, active-high): shadow and active bounds 0, all enables 0, FSM IDLE, cfg_ready=1, commit_pending=0, commit_done=0, mask=0, mask_valid=0.
- mask bit map:
  - [NREG-1:0]: per-region hit; bits >= NREG are 0.
  - [8]: OR of [7:0].
  - [10:9]: low 2 bits of the lowest-numbered hit index; 0 if no hit.
- Hit rule: region r enabled && x_min<=tv_x<=x_max && y_min<=tv_y<=y_max, all bounds inclusive and unsigned.
  - x_min>x_max or y_min>y_max: region never hits; no error flag.
- Latency is 1 cycle:
  - mask and mask_valid are registered from tv_x/tv_y/pix_valid.
  - pix_valid=0: mask_valid=0 next cycle and mask holds its previous value.
- Writes:
  - Accepted on cfg_wr && cfg_ready; update the shadow only.
  - Region index >= NREG: accepted, discarded.
  - Enable-register write: shadow_en <= cfg_data[NREG-1:0].
- FSM IDLE:
  - cfg_ready=1.
  - cfg_commit -> PENDING, commit_pending=1 next cycle.
  - A write and a commit in the same cycle: the write lands in the shadow first and is included in the commit.
- FSM PENDING:
  - cfg_ready=0; writes are stalled and the host holds cfg_wr.
  - A repeated cfg_commit has no effect.
  - On frame_start: active <= shadow, commit_done=1 for one cycle, commit_pending=0, back to IDLE.
- frame_start in the same cycle as cfg_commit while IDLE: no commit on that frame; the commit applies at the following frame_start.
- The pixel that coincides with the commit frame_start is evaluated against the new active set, because the copy and the compare use the same edge. Active values are bypassed in that cycle.
- Reset mid-PENDING: commit abandoned, all state back to reset values.

Optional Feature:
- Macro: MASK_BORDER_EN.
- Defined: a region hits only on its perimeter, i.e. in-rect && (tv_x==x_min || tv_x==x_max || tv_y==y_min || tv_y==y_max). Used for on-screen outline debug. A single-column region (x_min==x_max) is fully lit.
- Undefined: filled-rectangle hit as above; no perimeter logic is synthesised.

Test Plan:
- Reset, then a raster at (100,50) -> mask=0, mask_valid=1 one cycle after pix_valid, cfg_ready=1.
- Program region 0 = x 40..40, y 2..8, enable=0x01, commit, then frame_start -> commit_done pulse; (40,5) gives mask=0x101; (40,9) and (41,5) give 0.
- Regions 1 and 3 overlap at (200,100), enable=0x0A -> mask[7:0]=0x0A, mask[8]=1, mask[10:9]=1.
- Commit pending, cfg_wr held to region 2 -> cfg_ready=0 until frame_start; the write lands after commit_done; the active set excludes it until the next commit.
- cfg_commit and frame_start in the same cycle -> no commit_done; commit_done on the next frame_start.
- x_min=300, x_max=100 enabled -> never hits.
- With MASK_BORDER_EN, rect 10..20 x 10..20: (15,15) gives 0 and (10,15) gives a hit.
